led_fade_4: RTL
===============

LED_FADE_4 -- requirements
Module: led_fade_4

Interface
REQ-001 SHALL have parameter PWM_BITS, default 4, PWM counter width; PWM period = 2^PWM_BITS clocks.
REQ-002 SHALL have parameter STEP_DIV, default 2, PWM periods per fade step (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port led_in  input  4  target on/off levels from the led_1_4 stage; bit0=led_1 ... bit3=led_4; synchronous to clk.
REQ-006 SHALL have port pwm_out  output  4  dimmed LED drive, bit i follows led_in[i]; registered.
REQ-007 SHALL have port settled  output  1  high when every channel duty equals its target (0 or DMAX); registered.

Function
REQ-008 SHALL keep a free-running counter pcnt (PWM_BITS wide), +1 every clk, wrapping from 2^PWM_BITS-1 to 0.
REQ-009 SHALL define period end (PE) as the cycle where pcnt = 2^PWM_BITS-1.
REQ-010 SHALL keep a step counter scnt (8 bits), +1 on each PE; at PE with scnt = STEP_DIV-1 it SHALL raise a one-cycle step tick and clear scnt to 0.
REQ-011 SHALL hold per channel a duty register duty[i], PWM_BITS+1 wide, range 0..DMAX where DMAX = 2^PWM_BITS.
REQ-012 SHALL, on step tick, set duty[i] to duty[i]+1 if led_in[i]=1 and duty[i]<DMAX; to duty[i]-1 if led_in[i]=0 and duty[i]>0; else hold (saturate at both ends, no wrap).
REQ-013 SHALL change duty only on PE cycles, so each PWM period uses one constant duty (no glitch pulses).
REQ-014 SHALL register pwm_out[i] <= (pcnt < duty[i]); latency one clk from counter to pin; duty 0 gives constant low, duty DMAX gives constant high.
REQ-015 SHALL sample led_in only on tick cycles; led_in toggling between ticks has no effect other than the value present at the tick.
REQ-016 SHALL reverse direction on the next tick when led_in[i] changes mid-ramp, starting from the current duty (no jump).
REQ-017 SHALL register settled <= AND over i of (duty[i] = (led_in[i] ? DMAX : 0)), evaluated every clk.
REQ-018 SHALL treat all four channels independently; simultaneous ramps in both directions are legal.

Reset
REQ-019 SHALL, while rst=0, asynchronously force pcnt=0, scnt=0, all duty=0, pwm_out=4'b0000, settled=0.
REQ-020 SHALL, on rst release, start pcnt at 0 on the first rising clk edge; first PE is 2^PWM_BITS clocks later.
REQ-021 SHALL, on reset mid-ramp, discard all fade progress; after release fades restart from duty 0.

Configuration
REQ-022 SHALL use macro LED_FADE_RAMP_EN to select fading.
REQ-023 SHALL, with LED_FADE_RAMP_EN defined, behave per REQ-010..REQ-016.
REQ-024 SHALL, with LED_FADE_RAMP_EN undefined, omit scnt, set duty[i] to (led_in[i] ? DMAX : 0) on every PE, and keep all other behaviour and ports unchanged.

Verification
REQ-025 SHALL check reset: rst=0 with led_in=4'b1111 -> pwm_out=0000, settled=0, held throughout reset.
REQ-026 SHALL check fade-up (defaults, RAMP_EN): led_in=0001 from release -> pwm_out[0] high 1 clk per 16-clk period after 2 periods, full on (constant high) after 32 periods (512 clk), settled=1 then.
REQ-027 SHALL check fade-down: from settled all-on, led_in=0000 -> duty falls by 1 every 32 clk, all outputs constant low after 512 clk, settled=1.
REQ-028 SHALL check reversal: led_in[2] 1 for 10 ticks then 0 -> duty[2] peaks at 10, then returns to 0 in 10 ticks; no period with duty jump larger than 1.
REQ-029 SHALL check mixed channels: led_in=1010 from half-duty (8) on all -> ch1/ch3 rise, ch0/ch2 fall simultaneously; settled stays 0 until all reach target.
REQ-030 SHALL check without LED_FADE_RAMP_EN: led_in=1111 -> all pwm_out constant high from the clk after the first PE (clk 17 after release).

Source files
------------

// File: rtl/led_fade_4.sv
// led_fade_4: four-channel LED dimmer that turns on/off levels into PWM drive.
// A free-running PWM counter sets the period; each channel keeps a duty
// register that only changes at the end of a period, so no partial pulses.
// Build option: define LED_FADE_RAMP_EN to fade each channel one duty step
// at a time. Without it, duty jumps straight to full on/off at each period end.
module led_fade_4 #(
    parameter int PWM_BITS = 4,
    parameter int STEP_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] led_in,
    output logic [3:0] pwm_out,
    output logic       settled
);

    localparam int DW = PWM_BITS + 1;
    localparam logic [DW-1:0] DMAX = {1'b1, {PWM_BITS{1'b0}}};

    // The step counter is 8 bits wide, so the divider has to fit in 1..255.
    generate
        if (STEP_DIV < 1 || STEP_DIV > 255) begin : g_badStepDiv
            $error("led_fade_4: STEP_DIV must be in 1..255");
        end
    endgenerate

    logic [PWM_BITS-1:0] r_pcnt;
    logic                w_pe;
    logic [3:0][DW-1:0]  r_duty;
    logic [3:0][DW-1:0]  w_dutyNext;
    logic [3:0]          w_pwmNext;
    logic                w_allAtTarget;

    assign w_pe = (r_pcnt == {PWM_BITS{1'b1}});

    // Free-running PWM counter; its wrap point marks the end of each period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PWM_BITS'(1);
        end
    end

`ifdef LED_FADE_RAMP_EN
    logic [7:0] r_scnt;
    logic       w_tick;

    assign w_tick = w_pe && (r_scnt == 8'(STEP_DIV - 1));

    // Counts period ends and restarts every STEP_DIV periods; the tick is the
    // only moment the fade logic looks at led_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            r_scnt <= '0;
        end else if (w_pe) begin
            r_scnt <= r_scnt + 8'd1;
        end
    end

    // On a tick each channel moves one step toward its target and saturates
    // at 0 and DMAX; a changed target simply reverses from the current duty.
    always_comb begin
        w_dutyNext = r_duty;
        for (int i = 0; i < 4; i++) begin
            if (w_tick) begin
                if (led_in[i] && (r_duty[i] < DMAX)) begin
                    w_dutyNext[i] = r_duty[i] + DW'(1);
                end else if (!led_in[i] && (r_duty[i] != '0)) begin
                    w_dutyNext[i] = r_duty[i] - DW'(1);
                end
            end
        end
    end
`else
    // Without fading, each period end loads the channel straight to full on
    // or full off, so the output follows led_in with at most a period of lag.
    always_comb begin
        w_dutyNext = r_duty;
        for (int i = 0; i < 4; i++) begin
            if (w_pe) begin
                w_dutyNext[i] = led_in[i] ? DMAX : '0;
            end
        end
    end
`endif

    // Duty registers; every change lands on a period-end edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty <= '0;
        end else begin
            r_duty <= w_dutyNext;
        end
    end

    // PWM compare and the "every channel at its target" condition. Duty DMAX
    // exceeds every counter value, which gives a constant-high output.
    always_comb begin
        w_allAtTarget = 1'b1;
        w_pwmNext     = '0;
        for (int i = 0; i < 4; i++) begin
            w_pwmNext[i] = ({1'b0, r_pcnt} < r_duty[i]);
            if (r_duty[i] != (led_in[i] ? DMAX : '0)) begin
                w_allAtTarget = 1'b0;
            end
        end
    end

    // Registered outputs, one clock after the counter and duty they came from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= '0;
            settled <= 1'b0;
        end else begin
            pwm_out <= w_pwmNext;
            settled <= w_allAtTarget;
        end
    end

endmodule
